// File: rtl/distance_bcd_conv_if.sv
// distance_bcd_conv_if: start/value request and BCD result bundle for the distance converter
interface distance_bcd_conv_if #(
  parameter int BIN_W  = 9,
  parameter int DIGITS = 3
);
  logic                  i_start;
  logic [BIN_W-1:0]      i_bin;
  logic                  o_busy;
  logic                  o_done;
  logic [4*DIGITS-1:0]   o_bcd;
  logic [DIGITS-1:0]     o_blank;
  logic                  o_ovf;
  modport master (output i_start, i_bin, input o_busy, o_done, o_bcd, o_blank, o_ovf);
  modport slave  (input i_start, i_bin, output o_busy, o_done, o_bcd, o_blank, o_ovf);
endinterface

// File: rtl/distance_bcd_conv.sv
// distance_bcd_conv: shift-and-add-3 binary to BCD, one bit per clock, with blank mask and saturation
module distance_bcd_conv #(
  parameter int BIN_W  = 9,
  parameter int DIGITS = 3
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  distance_bcd_conv_if.slave   bus
);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SW = 4 * DIGITS;
  localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [SW-1:0] scr_q, scr_d, bcd_q, bcd_d, adj, nxt, fin;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic flag_q, flag_d, ovf_q, ovf_d, done_q, done_d, zero;
  logic [DIGITS-1:0] blank_q, blank_d, blank_n;
  always_comb begin
    adj = scr_q;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k +: 4] = scr_q[4*k +: 4] >= 4'd5 ? scr_q[4*k +: 4] + 4'd3 : scr_q[4*k +: 4];
    nxt = (adj << 1) | SW'(shift_q[BIN_W-1]);
    fin = flag_q ? {DIGITS{4'h9}} : nxt;
  end
  // a digit is a leading zero only if it and every more significant digit are zero
  always_comb begin
    blank_n = '0;
    zero = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero = zero & (fin[4*k +: 4] == 4'd0);
      blank_n[k] = zero & ~flag_q;
    end
  end
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (bus.i_start) begin
        state_d = SHIFT;
        shift_d = bus.i_bin;
        scr_d   = '0;
        cnt_d   = CNT_W'(BIN_W);
        flag_d  = 64'(bus.i_bin) > MAX_VAL;
      end
    end else begin
      scr_d   = nxt;
      shift_d = shift_q << 1;
      cnt_d   = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        bcd_d   = fin;
        blank_d = blank_n;
        ovf_d   = flag_q;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end
  assign bus.o_busy  = state_q == SHIFT;
  assign bus.o_done  = done_q;
  assign bus.o_bcd   = bcd_q;
  assign bus.o_blank = blank_q;
  assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_distance_bcd_conv.sv
// tb_distance_bcd_conv: scoreboard bench driving a 3-digit and a 2-digit converter with the same stimulus
module tb_distance_bcd_conv;
  typedef struct {
    logic [11:0] bcd;
    logic [2:0]  blank;
    logic        ovf;
    int          due;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [8:0] bin = '0;
  int checks = 0;
  int errors = 0;
  int ncnt = 0;
  int bl3 = 0;
  int bl2 = 0;
  logic pd3 = 1'b0;
  logic pd2 = 1'b0;
  exp_t q3[$];
  exp_t q2[$];
  exp_t e;
  always #5 clk = ~clk;
  distance_bcd_conv_if #(.BIN_W(9), .DIGITS(3)) a();
  distance_bcd_conv_if #(.BIN_W(9), .DIGITS(2)) b();
  assign a.i_start = start;
  assign a.i_bin   = bin;
  assign b.i_start = start;
  assign b.i_bin   = bin;
  distance_bcd_conv #(.BIN_W(9), .DIGITS(3)) dut3 (.i_Clk(clk), .i_Rst_n(rst_n), .bus(a));
  distance_bcd_conv #(.BIN_W(9), .DIGITS(2)) dut2 (.i_Clk(clk), .i_Rst_n(rst_n), .bus(b));
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", n, act, exp, $time);
    end
  endtask
  function automatic exp_t model(int v, int d, int due);
    exp_t r;
    int p;
    int w;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    r.bcd = '0;
    r.blank = '0;
    r.due = due;
    r.ovf = v > p - 1;
    w = 1;
    for (int k = 0; k < d; k++) begin
      r.bcd[4*k +: 4] = r.ovf ? 4'd9 : 4'((v / w) % 10);
      if (k > 0) r.blank[k] = !r.ovf && (v < w);
      w = w * 10;
    end
    return r;
  endfunction
  always @(negedge clk) begin
    ncnt++;
    if (!rst_n) begin
      bl3 = 0; bl2 = 0; pd3 = 1'b0; pd2 = 1'b0;
    end else begin
      if (a.o_busy) bl3++;
      if (b.o_busy) bl2++;
      if (a.o_done) begin
        chk("done_width3", 32'(pd3), 0);
        chk("busy_len3", bl3, 9);
        chk("busy_at_done3", 32'(a.o_busy), 0);
        bl3 = 0;
        if (q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done3 got=done want=idle at t=%0t", $time);
        end else begin
          e = q3.pop_front();
          chk("bcd3", 32'(a.o_bcd), 32'(e.bcd));
          chk("blank3", 32'(a.o_blank), 32'(e.blank));
          chk("ovf3", 32'(a.o_ovf), 32'(e.ovf));
          chk("latency3", ncnt, e.due);
        end
      end
      if (b.o_done) begin
        chk("done_width2", 32'(pd2), 0);
        chk("busy_len2", bl2, 9);
        bl2 = 0;
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done2 got=done want=idle at t=%0t", $time);
        end else begin
          e = q2.pop_front();
          chk("bcd2", 32'(b.o_bcd), 32'(e.bcd[7:0]));
          chk("blank2", 32'(b.o_blank), 32'(e.blank[1:0]));
          chk("ovf2", 32'(b.o_ovf), 32'(e.ovf));
          chk("latency2", ncnt, e.due);
        end
      end
      pd3 = a.o_done;
      pd2 = b.o_done;
    end
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic convert(int v, int gap, bit pulse);
    bit got;
    got = 1'b0;
    repeat (gap) tick();
    start = 1'b1;
    bin = 9'(v);
    q3.push_back(model(v, 3, ncnt + 10));
    q2.push_back(model(v, 2, ncnt + 10));
    tick();
    start = 1'b0;
    bin = 9'($urandom);
    for (int i = 0; i < 30; i++) begin
      if (a.o_done) begin
        got = 1'b1;
        break;
      end
      start = (i == 3) && pulse;
      if (start) bin = 9'($urandom);
      tick();
    end
    start = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout got=no_done want=done value=%0d", v);
    end
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_busy", 32'(a.o_busy), 0);
    chk("rst_done", 32'(a.o_done), 0);
    chk("rst_bcd", 32'(a.o_bcd), 0);
    chk("rst_blank3", 32'(a.o_blank), 32'h6);
    chk("rst_ovf", 32'(a.o_ovf), 0);
    chk("rst_blank2", 32'(b.o_blank), 32'h2);
    rst_n = 1'b1;
    convert(0, 0, 1'b0);
    convert(255, 1, 1'b0);
    convert(7, 0, 1'b0);
    convert(511, 2, 1'b1);
    start = 1'b1;
    bin = 9'd300;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 32'(a.o_busy), 0);
    chk("abort_done", 32'(a.o_done), 0);
    chk("abort_bcd", 32'(a.o_bcd), 0);
    chk("abort_blank", 32'(a.o_blank), 32'h6);
    chk("abort_ovf", 32'(a.o_ovf), 0);
    repeat (12) tick();
    convert(42, 0, 1'b0);
    convert(100, 0, 1'b1);
    convert(99, 0, 1'b0);
    for (int v = 0; v < 512; v++) convert(v, int'($urandom_range(3)), bit'($urandom_range(1)));
    repeat (15) tick();
    chk("drain3", q3.size(), 0);
    chk("drain2", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
